// File: rtl/score_display_if.sv
// Interface between the game core and the score/7-segment display block.
//   point_scored : score event, rising edge adds 1
//   score_clr    : synchronous clear of the current score
//   show_best    : 1 = display best score, 0 = display current score
//   score_bcd    : current score, 4-digit BCD
//   best_bcd     : best score since reset, 4-digit BCD
//   an           : digit anodes, active-low one-hot, an[0] = units
//   seg          : cathodes, active-low, {g,f,e,d,c,b,a}
//   dp           : decimal point, active-low (always off)
interface score_display_if;
  logic        point_scored;
  logic        score_clr;
  logic        show_best;
  logic [15:0] score_bcd;
  logic [15:0] best_bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output point_scored, score_clr, show_best,
    input  score_bcd, best_bcd, an, seg, dp
  );

  modport slave (
    input  point_scored, score_clr, show_best,
    output score_bcd, best_bcd, an, seg, dp
  );
endinterface

// File: rtl/score_display.sv
// 4-digit BCD score counter with best-score register, driving a Basys3
// 4-digit multiplexed common-anode 7-segment display.
//   clk148 : system clock, all registers on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : score_display_if slave (event/clear/select in, score/display out)
// Parameters:
//   REFRESH_DIV : clk148 cycles per digit slot (>= 2)
//   BLANK_LZ    : 1 = blank leading zeros on digits 3..1
module score_display #(
  parameter int unsigned REFRESH_DIV = 148500,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input logic            clk148,
  input logic            rst_n,
  score_display_if.slave bus
);

  localparam int unsigned   DW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  logic          prev_q, prev_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   best_q, best_d;
  logic [DW-1:0] div_q, div_d;
  digit_e        idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          inc;
  logic          carry;
  logic [15:0]   score_inc;
  logic [15:0]   src;
  digit_e        idx_nxt;
  logic [3:0]    lz_blank;
  logic [3:0]    digit;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // BCD +1: ripple the carry upward while digits roll over 9 -> 0.
  always_comb begin
    carry     = 1'b1;
    score_inc = score_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Values for the slot that starts at the next terminal count. The display
  // source is sampled only here, so a show_best change waits for a boundary.
  always_comb begin
    idx_nxt = DIG0;
    case (idx_q)
      DIG0:    idx_nxt = DIG1;
      DIG1:    idx_nxt = DIG2;
      DIG2:    idx_nxt = DIG3;
      default: idx_nxt = DIG0;
    endcase

    src         = bus.show_best ? best_q : score_q;
    lz_blank[3] = BLANK_LZ && (src[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (src[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (src[7:4] == 4'd0);
    lz_blank[0] = 1'b0;

    digit = src[3:0];
    case (idx_nxt)
      DIG1:    digit = src[7:4];
      DIG2:    digit = src[11:8];
      DIG3:    digit = src[15:12];
      default: digit = src[3:0];
    endcase

    seg_nxt = lz_blank[idx_nxt] ? 7'h7F : seg7(digit);
    an_nxt  = ~(4'b0001 << idx_nxt);
  end

  always_comb begin
    prev_d  = bus.point_scored;
    inc     = bus.point_scored & ~prev_q;

    score_d = score_q;
    if (bus.score_clr) begin
      score_d = '0;
    end else if (inc) begin
      score_d = score_inc;
    end

    best_d = best_q;
    if (score_q > best_q) begin
      best_d = score_q;
    end

    div_d = div_q + 1'b1;
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_nxt;
      an_d  = an_nxt;
      seg_d = seg_nxt;
    end
  end

  always_ff @(posedge clk148 or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      score_q <= '0;
      best_q  <= '0;
      div_q   <= '0;
      idx_q   <= DIG0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
      dp_q    <= 1'b1;
    end else begin
      prev_q  <= prev_d;
      score_q <= score_d;
      best_q  <= best_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.best_bcd  = best_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int K_SCORE = 0;
  localparam int K_BEST  = 1;
  localparam int K_AN    = 2;
  localparam int K_SEG   = 3;
  localparam int K_DP    = 4;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] SB = 7'h7F;

  typedef struct {
    int unsigned due;
    int          kind;
    logic [15:0] exp;
  } chk_t;

  logic clk;
  logic rst_n;

  score_display_if bus ();

  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk148 (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  chk_t        q[$];
  int unsigned cyc    = 0;
  int unsigned r0     = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;
  int unsigned m_score = 0;
  int unsigned m_best  = 0;
  logic [15:0] act;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_SCORE: return "score_bcd";
      K_BEST:  return "best_bcd";
      K_AN:    return "an";
      K_SEG:   return "seg";
      default: return "dp";
    endcase
  endfunction

  function automatic logic [15:0] bcd(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Monitor: compares every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        case (q[i].kind)
          K_SCORE: act = bus.score_bcd;
          K_BEST:  act = bus.best_bcd;
          K_AN:    act = {12'd0, bus.an};
          K_SEG:   act = {9'd0, bus.seg};
          default: act = {15'd0, bus.dp};
        endcase
        n_cmp = n_cmp + 1;
        if (act !== q[i].exp) begin
          n_bad = n_bad + 1;
          $display("FAIL %s cyc=%0d actual=%h required=%h", kname(q[i].kind), cyc, act, q[i].exp);
        end
        q.delete(i);
      end else if (q[i].due < cyc) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s cyc=%0d actual=missed required=%h", kname(q[i].kind), q[i].due, q[i].exp);
        q.delete(i);
      end
    end
  end

  task automatic push(input int kind, input int unsigned due, input logic [15:0] exp);
    chk_t c;
    c.due  = due;
    c.kind = kind;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    m_score = 0;
    m_best  = 0;
    push(K_SCORE, cyc, 16'h0000);
    push(K_BEST,  cyc, 16'h0000);
    push(K_AN,    cyc, 16'h000E);
    push(K_SEG,   cyc, 16'h0040);
    push(K_DP,    cyc, 16'h0001);
    repeat (3) tick;
    rst_n = 1'b1;
    r0    = cyc;
  endtask

  task automatic pulse(input bit chk);
    int unsigned n0 = cyc;
    logic [15:0] old_s = bcd(m_score);
    logic [15:0] old_b = bcd(m_best);
    bus.point_scored = 1'b1;
    m_score = (m_score + 1) % 10000;
    if (m_score > m_best) m_best = m_score;
    if (chk) begin
      push(K_SCORE, n0,     old_s);
      push(K_SCORE, n0 + 1, bcd(m_score));
      push(K_BEST,  n0 + 1, old_b);
      push(K_BEST,  n0 + 2, bcd(m_best));
    end
    tick;
    bus.point_scored = 1'b0;
    tick;
  endtask

  task automatic pulses(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pulse(1'b0);
  endtask

  task automatic clear(input bit with_pulse);
    int unsigned n0 = cyc;
    bus.score_clr    = 1'b1;
    bus.point_scored = with_pulse;
    m_score = 0;
    push(K_SCORE, n0 + 1, 16'h0000);
    push(K_BEST,  n0 + 2, bcd(m_best));
    tick;
    bus.score_clr    = 1'b0;
    bus.point_scored = 1'b0;
    tick;
  endtask

  task automatic sync_frame;
    while (((cyc - r0) % 16) != 0) tick;
  endtask

  task automatic disp_chk(input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s;
    sync_frame();
    for (int unsigned k = 0; k < 20; k++) begin
      case ((k / 4) % 4)
        0: s = s0;
        1: s = s1;
        2: s = s2;
        default: s = s3;
      endcase
      push(K_AN,  cyc + k, {12'd0, ~(4'b0001 << ((k / 4) % 4))});
      push(K_SEG, cyc + k, {9'd0, s});
      push(K_DP,  cyc + k, 16'h0001);
    end
    repeat (20) tick;
  endtask

  initial begin
    logic [6:0] s;
    int unsigned n0;
    rst_n            = 1'b0;
    bus.point_scored = 1'b0;
    bus.score_clr    = 1'b0;
    bus.show_best    = 1'b0;
    tick;

    // Reset state, and still slot 0 just after release
    do_reset();
    push(K_SCORE, cyc + 1, 16'h0000);
    push(K_AN,    cyc + 1, 16'h000E);
    push(K_SEG,   cyc + 1, 16'h0040);
    push(K_DP,    cyc + 1, 16'h0001);
    repeat (2) tick;

    // Three single pulses, then one held 10 cycles counts once
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b1);
    n0 = cyc;
    bus.point_scored = 1'b1;
    m_score = 4;
    m_best  = 4;
    push(K_SCORE, n0,     16'h0003);
    push(K_SCORE, n0 + 1, 16'h0004);
    push(K_SCORE, n0 + 9, 16'h0004);
    repeat (10) tick;
    bus.point_scored = 1'b0;
    tick;
    push(K_SCORE, cyc, 16'h0004);
    tick;

    // Carry across digits and full wrap
    clear(1'b0);
    pulses(998);
    pulse(1'b1);
    push(K_SCORE, cyc, 16'h0999);
    pulse(1'b1);
    push(K_SCORE, cyc, 16'h1000);
    pulses(8998);
    pulse(1'b1);
    push(K_SCORE, cyc, 16'h9999);
    pulse(1'b1);
    push(K_SCORE, cyc, 16'h0000);
    push(K_BEST,  cyc, 16'h9999);
    tick;

    // Clear wins over a simultaneous pulse; best is kept
    do_reset();
    pulses(41);
    pulse(1'b1);
    push(K_SCORE, cyc, 16'h0042);
    clear(1'b1);
    push(K_SCORE, cyc, 16'h0000);
    push(K_BEST,  cyc, 16'h0042);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    push(K_SCORE, cyc, 16'h0005);
    push(K_BEST,  cyc, 16'h0042);
    tick;

    // Multiplexing with leading-zero blanking
    clear(1'b0);
    pulses(304);
    pulse(1'b1);
    disp_chk(S5, S0, S3, SB);
    clear(1'b0);
    disp_chk(S0, SB, SB, SB);

    // show_best raised mid-slot: slot 0 keeps the score digit, best from slot 1
    sync_frame();
    n0 = cyc;
    for (int unsigned k = 0; k < 9; k++) begin
      if (k < 4) s = S0;
      else if (k < 8) s = S0;
      else s = S3;
      push(K_AN,  n0 + k, {12'd0, ~(4'b0001 << (k / 4))});
      push(K_SEG, n0 + k, {9'd0, s});
    end
    tick;
    bus.show_best = 1'b1;
    while ((cyc - n0) < 9) tick;

    // Async reset mid-slot, then restart at index 0
    do_reset();
    for (int unsigned k = 0; k < 9; k++) begin
      push(K_AN,  cyc + k, {12'd0, ~(4'b0001 << (k / 4))});
      push(K_SEG, cyc + k, (k < 4) ? 16'h0040 : 16'h007F);
    end
    repeat (12) tick;

    repeat (3) tick;
    if (q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL pending actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
